// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF = 27;
  localparam logic [CNT_W_DEF-1:0] DEFAULT_HALF_DEF = 27'h3FFFFFF;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned sel_w(input int unsigned channels);
    return (channels > 1) ? int'($clog2(channels)) : 1;
  endfunction

  // Half-period value giving f_out from f_clk.
  function automatic int unsigned half_for_hz(input int unsigned f_clk,
                                              input int unsigned f_out);
    return f_clk / (2 * f_out) - 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: free-running counter, staged half-period reload,
// square-wave output and a tick on every toggle.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned       CNT_W        = CNT_W_DEF,
  parameter logic [CNT_W-1:0]  DEFAULT_HALF = CNT_W'(DEFAULT_HALF_DEF)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_data,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pend
);

  logic [CNT_W-1:0] r_cnt, r_half, r_pend_val;
  logic             r_pend, r_clk, r_tick;

  logic [CNT_W-1:0] w_cnt_nxt, w_half_nxt, w_pend_val_nxt;
  logic             w_pend_nxt, w_clk_nxt, w_tick_nxt;
  logic             w_boundary, w_apply;

  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_half_nxt     = r_half;
    w_pend_val_nxt = r_pend_val;
    w_pend_nxt     = r_pend;
    w_clk_nxt      = r_clk;
    w_tick_nxt     = 1'b0;

    // >= keeps a count that overshot a freshly shrunk half from running away
    w_boundary = i_en && !i_sync && (r_cnt >= r_half);
    w_apply    = !i_en || i_sync || w_boundary;

    if (!i_en || i_sync) begin
      w_cnt_nxt = '0;
      w_clk_nxt = 1'b1;
    end else if (w_boundary) begin
      w_cnt_nxt  = '0;
      w_clk_nxt  = ~r_clk;
      w_tick_nxt = 1'b1;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    // A write landing on an apply event goes straight into half
    if (w_apply) begin
      w_pend_nxt = 1'b0;
      if (i_wr) begin
        w_half_nxt = i_data;
      end else if (r_pend) begin
        w_half_nxt = r_pend_val;
      end
    end else if (i_wr) begin
      w_pend_val_nxt = i_data;
      w_pend_nxt     = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_half     <= DEFAULT_HALF;
      r_pend_val <= DEFAULT_HALF;
      r_pend     <= 1'b0;
      r_clk      <= 1'b1;
      r_tick     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_half     <= w_half_nxt;
      r_pend_val <= w_pend_val_nxt;
      r_pend     <= w_pend_nxt;
      r_clk      <= w_clk_nxt;
      r_tick     <= w_tick_nxt;
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
  assign o_pend = r_pend;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: write decode and sync fan-out
// over CHANNELS independent clk_div_chan instances.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned      CHANNELS     = 4,
  parameter int unsigned      CNT_W        = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_DEF)
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        en,
  input  logic                       sync,
  input  logic                       div_wr,
  input  logic [sel_w(CHANNELS)-1:0] div_sel,
  input  logic [CNT_W-1:0]           div_data,
  output logic [CHANNELS-1:0]        clk_o,
  output logic [CHANNELS-1:0]        tick_o,
  output logic [CHANNELS-1:0]        pend_o
);

  logic [CHANNELS-1:0] w_wr;

  // Out-of-range selects match no channel and are dropped
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign w_wr[g] = div_wr && (32'(div_sel) == 32'(g));

    clk_div_chan #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .i_clk  (CLK),
      .i_rst  (rst),
      .i_en   (en[g]),
      .i_sync (sync),
      .i_wr   (w_wr[g]),
      .i_data (div_data),
      .o_clk  (clk_o[g]),
      .o_tick (tick_o[g]),
      .o_pend (pend_o[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: deadline-based reference model checked every cycle
// plus hand-computed directed expectations.
module tb_clk_div_multi;

  localparam int unsigned CH  = 4;
  localparam int unsigned CHB = 3;
  localparam int unsigned CW  = 8;
  localparam int unsigned DH  = 3;
  localparam int unsigned NM  = CH + CHB;

  logic           CLK = 1'b0;
  logic           rst, sync, div_wr, b_wr;
  logic [CH-1:0]  en;
  logic [1:0]     div_sel, b_sel;
  logic [CW-1:0]  div_data;
  logic [CH-1:0]  clk_o, tick_o, pend_o;
  logic [CHB-1:0] b_clk_o, b_tick_o, b_pend_o;

  always #5 CLK = ~CLK;

  clk_div_multi #(.CHANNELS(CH), .CNT_W(CW), .DEFAULT_HALF(8'(DH))) u_dut (
    .CLK(CLK), .rst(rst), .en(en), .sync(sync), .div_wr(div_wr),
    .div_sel(div_sel), .div_data(div_data),
    .clk_o(clk_o), .tick_o(tick_o), .pend_o(pend_o)
  );

  // Three-channel copy: its 2-bit select can address a non-existent channel
  clk_div_multi #(.CHANNELS(CHB), .CNT_W(CW), .DEFAULT_HALF(8'(DH))) u_dut_b (
    .CLK(CLK), .rst(rst), .en(en[CHB-1:0]), .sync(sync), .div_wr(b_wr),
    .div_sel(b_sel), .div_data(div_data),
    .clk_o(b_clk_o), .tick_o(b_tick_o), .pend_o(b_pend_o)
  );

  int unsigned m_half[NM];
  int unsigned m_pval[NM];
  bit          m_pend[NM];
  bit          m_clk[NM];
  bit          m_tick[NM];
  longint      m_dead[NM];
  longint      cyc = 0;
  bit          started = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each channel keeps the absolute cycle of its next toggle
  task automatic model_step();
    logic [NM-1:0] v_en;
    bit            e, w, bnd;
    int unsigned   d;
    cyc++;
    v_en = {en[CHB-1:0], en};
    d    = 32'(div_data);
    for (int k = 0; k < int'(NM); k++) begin
      e = bit'(v_en >> k);
      if (k < int'(CH)) w = div_wr && (int'(div_sel) == k);
      else              w = b_wr && (int'(b_sel) == k - int'(CH));
      if (rst) begin
        m_half[k] = DH;
        m_pval[k] = DH;
        m_pend[k] = 1'b0;
        m_clk[k]  = 1'b1;
        m_tick[k] = 1'b0;
        m_dead[k] = cyc + DH + 1;
      end else begin
        bnd = e && !sync && (cyc == m_dead[k]);
        if (!e || sync || bnd) begin
          if (w) m_half[k] = d;
          else if (m_pend[k]) m_half[k] = m_pval[k];
          m_pend[k] = 1'b0;
          m_dead[k] = cyc + m_half[k] + 1;
          m_tick[k] = bnd;
          m_clk[k]  = bnd ? !m_clk[k] : 1'b1;
        end else begin
          m_tick[k] = 1'b0;
          if (w) begin
            m_pval[k] = d;
            m_pend[k] = 1'b1;
          end
        end
      end
    end
    if (rst) started = 1'b1;
  endtask

  task automatic compare_all();
    logic [NM-1:0] a_clk, a_tick, a_pend;
    a_clk  = {b_clk_o, clk_o};
    a_tick = {b_tick_o, tick_o};
    a_pend = {b_pend_o, pend_o};
    for (int k = 0; k < int'(NM); k++) begin
      check($sformatf("cyc%0d ch%0d clk_o", cyc, k), 64'(1'(a_clk >> k)), 64'(m_clk[k]));
      check($sformatf("cyc%0d ch%0d tick_o", cyc, k), 64'(1'(a_tick >> k)), 64'(m_tick[k]));
      check($sformatf("cyc%0d ch%0d pend_o", cyc, k), 64'(1'(a_pend >> k)), 64'(m_pend[k]));
    end
  endtask

  initial begin : model_compare
    forever begin
      @(posedge CLK);
      model_step();
      #1;
      if (started) compare_all();
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Comments E<n> count rising edges from the one that first samples en high.
  initial begin : stimulus
    rst = 1'b1; en = '0; sync = 1'b0; div_wr = 1'b0; b_wr = 1'b0;
    div_sel = '0; b_sel = '0; div_data = '0;
    step(3);
    check("reset clk_o", clk_o, 4'hF);
    check("reset tick_o", tick_o, 4'h0);
    check("reset pend_o", pend_o, 4'h0);

    rst = 1'b0; en = 4'hF;
    step(3);                                   // E3
    check("pre-fall clk_o", clk_o, 4'hF);
    step(1);                                   // E4: first fall
    check("first fall clk_o", clk_o, 4'h0);
    check("first fall tick_o", tick_o, 4'hF);
    step(1);                                   // E5
    check("no tick mid-half", tick_o, 4'h0);
    step(3);                                   // E8: rise, period 8
    check("first rise clk_o", clk_o, 4'hF);
    check("first rise tick_o", tick_o, 4'hF);

    step(1);                                   // E9: mid half-period
    div_wr = 1'b1; div_sel = 2'd1; div_data = 8'd0;
    step(1);                                   // E10: staged
    div_wr = 1'b0;
    check("ch1 staged pend_o", pend_o, 4'b0010);
    step(2);                                   // E12: applied at boundary
    check("ch1 applied pend_o", pend_o, 4'b0000);
    check("E12 clk_o", clk_o, 4'b0000);
    step(1);                                   // E13: ch1 now CLK/2
    check("ch1 fast clk_o", clk_o, 4'b0010);
    step(1);                                   // E14
    check("ch1 fast clk_o 2", clk_o, 4'b0000);
    check("ch1 fast tick_o", tick_o, 4'b0010);

    step(1);                                   // E15
    div_wr = 1'b1; div_sel = 2'd2; div_data = 8'd7;
    step(1);                                   // E16: write on ch2 boundary
    div_wr = 1'b0;
    check("ch2 bypass pend_o", pend_o, 4'b0000);
    check("E16 clk_o", clk_o, 4'b1101);
    check("E16 tick_o", tick_o, 4'b1111);
    step(7);                                   // E23
    check("ch2 long half clk", clk_o[2], 1'b1);
    step(1);                                   // E24
    check("E24 clk_o", clk_o, 4'b1001);
    check("E24 tick_o", tick_o, 4'b1111);

    step(3);                                   // E27
    div_wr = 1'b1; div_sel = 2'd0; div_data = 8'd5;
    step(1);                                   // E28: ch0 bypass, H=5
    div_wr = 1'b0;
    check("ch0 bypass pend_o", pend_o, 4'b0000);
    step(3);                                   // E31
    sync = 1'b1;
    step(1);                                   // E32: ch3 at boundary, ch0 mid
    sync = 1'b0;
    check("sync clk_o", clk_o, 4'hF);
    check("sync tick_o", tick_o, 4'h0);
    step(4);                                   // E36
    check("E36 clk_o", clk_o, 4'b0111);
    check("E36 tick_o", tick_o, 4'b1010);
    step(2);                                   // E38
    check("E38 clk_o", clk_o, 4'b0110);
    check("E38 tick_o", tick_o, 4'b0011);

    div_wr = 1'b1; div_sel = 2'd0; div_data = 8'd1;
    step(1);                                   // E39
    div_wr = 1'b0;
    check("ch0 staged pend_o", pend_o, 4'b0001);
    en = 4'b1110;
    step(1);                                   // E40: disabled applies
    check("disable pend_o", pend_o, 4'b0000);
    check("disable clk0", clk_o[0], 1'b1);
    step(1);                                   // E41
    en = 4'hF;
    step(1);                                   // E42
    check("reenable clk0", clk_o[0], 1'b1);
    step(1);                                   // E43: H=1 toggle
    check("reenable fall clk0", clk_o[0], 1'b0);
    check("reenable tick0", tick_o[0], 1'b1);

    b_wr = 1'b1; b_sel = 2'd3; div_data = 8'd0;
    step(1);                                   // E44: out-of-range select
    b_wr = 1'b0;
    check("bad sel pend_o", b_pend_o, 3'b000);
    div_wr = 1'b1; div_sel = 2'd3; div_data = 8'd2;
    b_wr = 1'b1; b_sel = 2'd1;
    step(1);                                   // E45
    div_wr = 1'b0; b_wr = 1'b0;
    check("ch3 staged pend_o", pend_o, 4'b1000);
    check("b ch1 staged pend_o", b_pend_o, 3'b010);

    rst = 1'b1;
    step(1);
    check("mid rst clk_o", clk_o, 4'hF);
    check("mid rst tick_o", tick_o, 4'h0);
    check("mid rst pend_o", pend_o, 4'h0);
    check("mid rst b clk_o", b_clk_o, 3'b111);
    check("mid rst b pend_o", b_pend_o, 3'b000);

    rst = 1'b0; en = 4'b0101;
    step(6);
    div_wr = 1'b1; div_sel = 2'd1; div_data = 8'd2;
    sync = 1'b1;
    step(1);
    sync = 1'b0; div_sel = 2'd3; div_data = 8'd1;
    step(1);
    div_wr = 1'b0; en = 4'hF;
    step(3);
    div_wr = 1'b1; div_sel = 2'd0; div_data = 8'd0;
    step(1);
    div_wr = 1'b0;
    step(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
